fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0: 0 = no parity bit, 1 = even parity bit after the data bits.
REQ-003 SHALL have parameter STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_enable, input, 1 bit: when high, the block may start new frames.
REQ-007 SHALL have port in_fifo_data, input, 8 bits: byte from the upstream FIFO, valid the cycle after a read pulse.
REQ-008 SHALL have port in_fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-009 SHALL have port out_fifo_read, output, 1 bit: one-cycle read pulse to the upstream FIFO.
REQ-010 SHALL have port out_tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port out_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port out_frame_done, output, 1 bit: one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-013 SHALL implement the states IDLE, FETCH, START, DATA, PARITY, STOP; all outputs SHALL be registered.
REQ-014 SHALL, in IDLE with in_enable=1 and in_fifo_empty=0, assert out_fifo_read for exactly one cycle and move to FETCH.
REQ-015 SHALL, in FETCH (one cycle), capture in_fifo_data into an 8-bit shift register and move to START.
REQ-016 SHALL never assert out_fifo_read outside IDLE, and never while in_fifo_empty=1, so at most one read is issued per frame.
REQ-017 SHALL drive out_tx low in START for CLKS_PER_BIT cycles.
REQ-018 SHALL, in DATA, send 8 bits LSB first, each held CLKS_PER_BIT cycles, counted by a 3-bit index.
REQ-019 SHALL, in PARITY (entered only when PARITY_EN=1), send the XOR of the 8 data bits for CLKS_PER_BIT cycles; when PARITY_EN=0, DATA SHALL go directly to STOP.
REQ-020 SHALL drive out_tx high in STOP for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-021 SHALL hold out_tx high in IDLE and FETCH.
REQ-022 SHALL time bits with a baud counter of width $clog2(CLKS_PER_BIT) that reloads to 0 at every bit boundary.
REQ-023 SHALL produce a frame of (9+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, from START entry to STOP exit.
REQ-024 SHALL place out_fifo_read at T, FETCH at T+1, and out_tx falling at T+2 (latency 2 from read pulse to start bit).
REQ-025 SHALL, back-to-back with a non-empty FIFO, leave exactly 2 idle-high cycles (IDLE, FETCH) between the end of one frame's stop bits and the next start bit.
REQ-026 SHALL, when in_enable drops mid-frame, complete the current frame and issue no further reads until in_enable=1.
REQ-027 SHALL ignore in_fifo_data outside the FETCH capture cycle; changes to in_fifo_empty mid-frame SHALL have no effect on the frame in progress.

Reset
REQ-028 SHALL, on rst=1 in any state (mid-frame included), immediately and without waiting for a clock: enter IDLE, set out_tx=1, out_fifo_read=0, out_busy=0, out_frame_done=0, and clear the counters and the shift register.
REQ-029 SHALL, after rst deasserts, issue no read before the first rising clk edge at which the conditions of REQ-014 hold.

Verification
REQ-030 Bench SHALL check, with CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, one byte 0xA5 in the FIFO: one read pulse at T, start bit at T+2, bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop bit, out_frame_done high at T+41, 40-cycle frame.
REQ-031 Bench SHALL check, with PARITY_EN=1, STOP_BITS=2, byte 0x07: parity bit = 1, frame = 48 cycles, out_tx high for the final 8 cycles.
REQ-032 Bench SHALL check three bytes 0x00, 0xFF, 0x3C queued: exactly 3 read pulses, frames in order, 2 idle cycles between frames, no read while in_fifo_empty=1.
REQ-033 Bench SHALL check rst asserted during the DATA state of byte 0x55: out_tx=1 and out_busy=0 with no clock edge; after release with the FIFO empty, no read pulse and out_tx stays 1.
REQ-034 Bench SHALL check in_enable dropped in START with 2 bytes queued: the current frame completes, there is no second read, and raising in_enable later sends the second byte.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO and serialises them.
// Frame: start bit, 8 data bits LSB first, optional even parity bit, 1-2 stop bits.
`timescale 1ns/1ps
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_enable,
    input  logic [7:0] in_fifo_data,
    input  logic       in_fifo_empty,
    output logic       out_fifo_read,
    output logic       out_tx,
    output logic       out_busy,
    output logic       out_frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic             stop_cnt, stop_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             parity_bit, parity_nxt;
    logic             tx_nxt, rd_nxt, busy_nxt, done_nxt;
    logic             baud_last;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            stop_cnt       <= 1'b0;
            shift_reg      <= '0;
            parity_bit     <= 1'b0;
            out_tx         <= 1'b1;
            out_fifo_read  <= 1'b0;
            out_busy       <= 1'b0;
            out_frame_done <= 1'b0;
        end else begin
            state          <= state_nxt;
            baud_cnt       <= baud_nxt;
            bit_idx        <= idx_nxt;
            stop_cnt       <= stop_nxt;
            shift_reg      <= shift_nxt;
            parity_bit     <= parity_nxt;
            out_tx         <= tx_nxt;
            out_fifo_read  <= rd_nxt;
            out_busy       <= busy_nxt;
            out_frame_done <= done_nxt;
        end
    end

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        idx_nxt    = bit_idx;
        stop_nxt   = stop_cnt;
        shift_nxt  = shift_reg;
        parity_nxt = parity_bit;

        case (state)
            // The read pulse is issued while still in IDLE; FETCH follows it.
            IDLE: begin
                if (out_fifo_read) state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt  = START;
                shift_nxt  = in_fifo_data;
                parity_nxt = even_parity(in_fifo_data);
                baud_nxt   = '0;
            end
            START: begin
                if (baud_last) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    idx_nxt   = '0;
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_nxt  = 1'b0;
                    end else begin
                        idx_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (baud_last) begin
                    state_nxt = STOP;
                    baud_nxt  = '0;
                    stop_nxt  = 1'b0;
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    if (stop_cnt == STOP_LAST) state_nxt = IDLE;
                    else                       stop_nxt  = stop_cnt + 1'b1;
                end else begin
                    baud_nxt = baud_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = parity_nxt;
            default: tx_nxt = 1'b1;
        endcase
        rd_nxt   = (state_nxt == IDLE) && in_enable && !in_fifo_empty;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == STOP) && (stop_nxt == STOP_LAST) && (baud_nxt == BAUD_LAST);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (8N1 and 8E2 at 4 clocks/bit), FIFO models,
// expected serial waveforms built from the byte and frame format.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic [7:0] fd_a = 8'h00, fd_b = 8'h00;
    logic       empty_a, empty_b;
    logic       rd_a, tx_a, busy_a, done_a;
    logic       rd_b, tx_b, busy_b, done_b;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
    int rd_empty_a = 0, rd_empty_b = 0, rd_cnt_a = 0;
    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int t_rd = 0, t_done = 0;

    logic use_b = 1'b0;
    wire tx_m   = use_b ? tx_b   : tx_a;
    wire rd_m   = use_b ? rd_b   : rd_a;
    wire busy_m = use_b ? busy_b : busy_a;
    wire done_m = use_b ? done_b : done_a;

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .in_enable(en_a), .in_fifo_data(fd_a),
        .in_fifo_empty(empty_a), .out_fifo_read(rd_a), .out_tx(tx_a),
        .out_busy(busy_a), .out_frame_done(done_a)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .in_enable(en_b), .in_fifo_data(fd_b),
        .in_fifo_empty(empty_b), .out_fifo_read(rd_b), .out_tx(tx_b),
        .out_busy(busy_b), .out_frame_done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO models: data appears the cycle after the read pulse.
    always @(posedge clk) begin
        if (rd_a) begin
            rd_cnt_a <= rd_cnt_a + 1;
            if (wp_a == rp_a) rd_empty_a <= rd_empty_a + 1;
            else begin
                fd_a <= mem_a[rp_a % 64];
                rp_a <= rp_a + 1;
            end
        end
        if (rd_b) begin
            if (wp_b == rp_b) rd_empty_b <= rd_empty_b + 1;
            else begin
                fd_b <= mem_b[rp_b % 64];
                rp_b <= rp_b + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic push(input bit sel, input logic [7:0] b);
        if (sel) begin
            mem_b[wp_b % 64] = b;
            wp_b++;
        end else begin
            mem_a[wp_a % 64] = b;
            wp_a++;
        end
    endtask

    task automatic wait_read(input bit sel, input int max_cyc, output int waited);
        use_b  = sel;
        waited = -1;
        for (int w = 1; w <= max_cyc; w++) begin
            @(negedge clk);
            check_val("idle_done", 32'(done_m), 32'd0);
            check_val("idle_tx", 32'(tx_m), 32'd1);
            if (rd_m) begin
                check_val("rd_busy", 32'(busy_m), 32'd0);
                waited = w;
                t_rd   = cyc;
                break;
            end
        end
        if (waited < 0) check_val("rd_seen", 32'(rd_m), 32'd1);
    endtask

    // Called on the read-pulse cycle; walks FETCH and the whole frame.
    task automatic run_frame(input bit sel, input logic [7:0] b, input int drop_at);
        bit bits[$];
        int total;
        int idx;
        use_b = sel;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (sel) bits.push_back(^b);
        for (int s = 0; s < (sel ? 2 : 1); s++) bits.push_back(1'b1);
        total = bits.size() * CPB;

        @(negedge clk);
        check_val("fetch_tx", 32'(tx_m), 32'd1);
        check_val("fetch_busy", 32'(busy_m), 32'd1);
        check_val("fetch_rd", 32'(rd_m), 32'd0);

        idx = 0;
        foreach (bits[k]) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                if (idx == drop_at) begin
                    if (sel) en_b = 1'b0;
                    else     en_a = 1'b0;
                end
                check_val($sformatf("tx[%0d] byte %02h", idx, b), 32'(tx_m), 32'(bits[k]));
                check_val($sformatf("busy[%0d]", idx), 32'(busy_m), 32'd1);
                check_val($sformatf("rd_mid[%0d]", idx), 32'(rd_m), 32'd0);
                check_val($sformatf("done[%0d]", idx), 32'(done_m), 32'(idx == total - 1));
                if (done_m) t_done = cyc;
                idx++;
            end
        end
    endtask

    initial begin
        int w;
        int rc0;
        logic [7:0] rb [5];
        logic [7:0] b;

        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        #1;
        check_val("rst_tx_a", 32'(tx_a), 32'd1);
        check_val("rst_busy_a", 32'(busy_a), 32'd0);
        check_val("rst_rd_a", 32'(rd_a), 32'd0);
        check_val("rst_done_a", 32'(done_a), 32'd0);
        check_val("rst_tx_b", 32'(tx_b), 32'd1);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        en_a = 1'b1;

        // Enabled but empty: no read.
        repeat (10) begin
            @(negedge clk);
            check_val("empty_no_rd", 32'(rd_a), 32'd0);
        end

        // 0xA5, 8N1
        push(0, 8'hA5);
        wait_read(0, 5, w);
        check_val("a5_rd_lat", w, 1);
        run_frame(0, 8'hA5, -1);
        check_val("a5_done_at", t_done - t_rd, 41);

        // 0x07, 8E2
        en_b = 1'b1;
        push(1, 8'h07);
        wait_read(1, 5, w);
        check_val("07_rd_lat", w, 1);
        run_frame(1, 8'h07, -1);
        check_val("07_frame_len", t_done - (t_rd + 2) + 1, 48);

        // Three queued bytes back to back
        rc0 = rd_cnt_a;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        wait_read(0, 5, w);
        run_frame(0, 8'h00, -1);
        wait_read(0, 5, w);
        check_val("gap_1", w, 1);
        run_frame(0, 8'hFF, -1);
        wait_read(0, 5, w);
        check_val("gap_2", w, 1);
        run_frame(0, 8'h3C, -1);
        repeat (20) begin
            @(negedge clk);
            check_val("drained_no_rd", 32'(rd_a), 32'd0);
        end
        check_val("three_reads", rd_cnt_a - rc0, 3);

        // Enable dropped during START with two bytes queued
        push(0, 8'h81);
        push(0, 8'h42);
        wait_read(0, 5, w);
        run_frame(0, 8'h81, 1);
        repeat (30) begin
            @(negedge clk);
            check_val("en_low_no_rd", 32'(rd_a), 32'd0);
            check_val("en_low_idle", 32'(busy_a), 32'd0);
        end
        en_a = 1'b1;
        wait_read(0, 5, w);
        check_val("en_high_rd_lat", w, 1);
        run_frame(0, 8'h42, -1);

        // Asynchronous reset in the middle of 0x55's data bits
        push(0, 8'h55);
        wait_read(0, 5, w);
        repeat (10) @(negedge clk);
        check_val("pre_rst_tx", 32'(tx_a), 32'd0);
        check_val("pre_rst_busy", 32'(busy_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_tx", 32'(tx_a), 32'd1);
        check_val("async_rst_busy", 32'(busy_a), 32'd0);
        check_val("async_rst_rd", 32'(rd_a), 32'd0);
        check_val("async_rst_done", 32'(done_a), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            check_val("post_rst_rd", 32'(rd_a), 32'd0);
            check_val("post_rst_tx", 32'(tx_a), 32'd1);
        end

        // Random bytes with random idle gaps, 8N1
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            push(0, b);
            wait_read(0, 5, w);
            check_val("rnd_a_rd_lat", w, 1);
            run_frame(0, b, -1);
        end

        // Random bytes queued back to back, 8E2
        for (int i = 0; i < 5; i++) begin
            rb[i] = 8'($urandom);
            push(1, rb[i]);
        end
        for (int i = 0; i < 5; i++) begin
            wait_read(1, 5, w);
            check_val("rnd_b_gap", w, 1);
            run_frame(1, rb[i], -1);
        end

        repeat (5) @(negedge clk);
        check_val("rd_empty_a", rd_empty_a, 0);
        check_val("rd_empty_b", rd_empty_b, 0);
        check_val("fifo_a_drained", wp_a - rp_a, 0);
        check_val("fifo_b_drained", wp_b - rp_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
